rf_cfg_sequencer: RTL

Table-driven AXI4-Lite master that brings up and reconfigures the RF data converter from a command table without CPU involvement. It fetches entries from an external command table (ROM/BRAM) and executes each entry as one of: a register write, a poll-until-match read, a fixed delay, or end. It sits in the `axilite_clk` domain in front of the converter's AXI4-Lite slave. It reports completion, or the failing entry and cause.

---
 rtl/rf_cfg_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rf_cfg_sequencer.sv
// rf_cfg_sequencer
//   Table-driven AXI4-Lite master that walks a command table (WRITE, POLL,
//   WAIT, END) and drives the RF data converter's register slave, so that
//   bring-up and reconfiguration need no CPU involvement.
//
// Ports
//   axilite_clk / axilite_rst : clock, asynchronous active-high reset
//   start, abort              : control pulses
//   busy, done, err,
//   err_code, err_idx         : status (err_code 1 = bad resp, 2 = poll timeout,
//                               3 = no END before last index, or aborted)
//   tbl_idx -> tbl_op/addr/data/mask : command table port, 1-cycle read latency
//   m_aw*/m_w*/m_b*/m_ar*/m_r*       : AXI4-Lite master
//
// Every output is a flop; the next value is computed in the single
// combinational process below.
module rf_cfg_sequencer #(
    parameter int ADDR_W     = 18,
    parameter int IDX_W      = 6,
    parameter int POLL_LIMIT = 1024
) (
    input  logic              axilite_clk,
    input  logic              axilite_rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [IDX_W-1:0]  err_idx,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic [1:0]        tbl_op,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,
    input  logic [31:0]       tbl_mask,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam int PC_W = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WR, S_WRESP,
        S_RD, S_RDATA, S_DELAY, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    tbl_idx_q, tbl_idx_d;
    logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]          err_code_q, err_code_d, cause_q, cause_d;
    logic [IDX_W-1:0]    err_idx_q, err_idx_d;
    logic                abort_q, abort_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d;
    logic [31:0]         data_q, data_d, mask_q, mask_d, dly_q, dly_d;
    logic [PC_W-1:0]     poll_q, poll_d;
    logic                adv, abort_any;

    always_ff @(posedge axilite_clk or posedge axilite_rst) begin
        if (axilite_rst) begin
            state_q    <= S_IDLE;
            tbl_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            cause_q    <= '0;
            err_idx_q  <= '0;
            abort_q    <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            data_q     <= '0;
            mask_q     <= '0;
            dly_q      <= '0;
            poll_q     <= '0;
        end else begin
            state_q    <= state_d;
            tbl_idx_q  <= tbl_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cause_q    <= cause_d;
            err_idx_q  <= err_idx_d;
            abort_q    <= abort_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            dly_q      <= dly_d;
            poll_q     <= poll_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tbl_idx_d  = tbl_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_code_d = err_code_q;
        cause_d    = cause_q;
        err_idx_d  = err_idx_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        data_d     = data_q;
        mask_d     = mask_q;
        dly_d      = dly_q;
        poll_d     = poll_q;
        adv        = 1'b0;
        // The live input is OR'ed in so an abort arriving in the same cycle as
        // a decision point is not lost to the one-cycle latch delay.
        abort_any  = abort_q | abort;
        // Abort is only remembered while a sequence runs; in IDLE it is dropped
        // (a coincident start wins).
        abort_d    = (state_q == S_IDLE) ? 1'b0 : abort_any;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    tbl_idx_d  = '0;
                    err_d      = 1'b0;
                    err_code_d = '0;
                    err_idx_d  = '0;
                    busy_d     = 1'b1;
                    poll_d     = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                data_d = tbl_data;
                mask_d = tbl_mask;
                case (tbl_op)
                    2'd0: begin
                        awaddr_d  = tbl_addr;
                        wdata_d   = tbl_data;
                        wstrb_d   = 4'hF;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end
                    2'd1: begin
                        araddr_d  = tbl_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD;
                    end
                    2'd2: begin
                        dly_d   = tbl_data;
                        state_d = S_DELAY;
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                endcase
            end
            S_WR: begin
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                // Leave once each channel is either already accepted or
                // being accepted this cycle.
                if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    if (m_bresp != 2'b00) begin
                        cause_d = 2'd1;
                        state_d = S_ERR;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (m_rvalid) begin
                    rready_d = 1'b0;
                    if (m_rresp != 2'b00) begin
                        cause_d = 2'd1;
                        state_d = S_ERR;
                    end else if ((m_rdata & mask_q) == (data_q & mask_q)) begin
                        adv = 1'b1;
                    end else if (poll_q == PC_W'(POLL_LIMIT - 1)) begin
                        cause_d = 2'd2;
                        state_d = S_ERR;
                    end else if (abort_any) begin
                        // Don't keep polling once asked to stop.
                        cause_d = 2'd3;
                        state_d = S_ERR;
                    end else begin
                        poll_d    = poll_q + PC_W'(1);
                        arvalid_d = 1'b1;
                        state_d   = S_RD;
                    end
                end
            end
            S_DELAY: begin
                if (abort_any) begin
                    cause_d = 2'd3;
                    state_d = S_ERR;
                end else if (dly_q == 32'd0) begin
                    adv = 1'b1;
                end else begin
                    dly_d = dly_q - 32'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                err_d      = 1'b1;
                err_code_d = cause_q;
                err_idx_d  = tbl_idx_q;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared advance point: the table never wraps, and a pending abort
        // ends the sequence here.
        if (adv) begin
            if (tbl_idx_q == '1 || abort_any) begin
                cause_d = 2'd3;
                state_d = S_ERR;
            end else begin
                tbl_idx_d = tbl_idx_q + IDX_W'(1);
                poll_d    = '0;
                state_d   = S_FETCH;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_idx   = err_idx_q;
    assign tbl_idx   = tbl_idx_q;
    assign m_awaddr  = awaddr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = araddr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule
